decode_queue: RTL and testbench

Buffered RV32I decode stage between instruction fetch and issue. Decodes each fetched instruction on entry and holds up to DEPTH decoded entries in a FIFO. Provides valid/ready handshakes on both sides, propagates the PC, flags illegal encodings, and supports a single-cycle flush on redirect. Op encodings are the 6-bit op macros from config.v (`NOP`, `LUI`, … `AND`).

---
 rtl/decode_queue.sv | 255 +++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage holding a FIFO of
// pre-decoded entries between instruction fetch and issue.
package decode_queue_pkg;
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_LB    = 6'd11;
  localparam logic [5:0] OP_LH    = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd13;
  localparam logic [5:0] OP_LBU   = 6'd14;
  localparam logic [5:0] OP_LHU   = 6'd15;
  localparam logic [5:0] OP_SB    = 6'd16;
  localparam logic [5:0] OP_SH    = 6'd17;
  localparam logic [5:0] OP_SW    = 6'd18;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;
  localparam logic [5:0] OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_ORI   = 6'd23;
  localparam logic [5:0] OP_ANDI  = 6'd24;
  localparam logic [5:0] OP_SLLI  = 6'd25;
  localparam logic [5:0] OP_SRLI  = 6'd26;
  localparam logic [5:0] OP_SRAI  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd28;
  localparam logic [5:0] OP_SUB   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_SLTU  = 6'd32;
  localparam logic [5:0] OP_XOR   = 6'd33;
  localparam logic [5:0] OP_SRL   = 6'd34;
  localparam logic [5:0] OP_SRA   = 6'd35;
  localparam logic [5:0] OP_OR    = 6'd36;
  localparam logic [5:0] OP_AND   = 6'd37;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_op,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_imm,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dec_t            dec_mem [DEPTH];
  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  dec_t            dec;
  dec_t            head;
  logic            bad;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alt;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign count     = cnt;
  assign in_ready  = rst & rdy & ~flush & (cnt < CW'(DEPTH));
  assign out_valid = rdy & (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head        = dec_mem[rd_ptr];
  assign out_op      = head.op;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign out_pc      = pc_mem[rd_ptr];

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign alt   = (f7 == 7'b0100000);
  assign rd_f  = in_inst[11:7];
  assign rs1_f = in_inst[19:15];
  assign rs2_f = in_inst[24:20];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25],
                  in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31],
                  in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};
  assign shamt = {27'b0, in_inst[24:20]};

  always_comb begin
    dec = '0;
    bad = 1'b0;
    unique case (opc)
      7'b0110111: begin
        dec.op = OP_LUI; dec.rd = rd_f; dec.imm = imm_u;
      end
      7'b0010111: begin
        dec.op = OP_AUIPC; dec.rd = rd_f; dec.imm = imm_u;
      end
      7'b1101111: begin
        dec.op = OP_JAL; dec.rd = rd_f; dec.imm = imm_j;
      end
      7'b1100111: begin
        dec.op  = OP_JALR;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = imm_i;
        bad     = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_b;
        unique case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i;
        unique case (f3)
          3'b000:  dec.op = OP_LB;
          3'b001:  dec.op = OP_LH;
          3'b010:  dec.op = OP_LW;
          3'b100:  dec.op = OP_LBU;
          3'b101:  dec.op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_s;
        unique case (f3)
          3'b000:  dec.op = OP_SB;
          3'b001:  dec.op = OP_SH;
          3'b010:  dec.op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i;
        unique case (f3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b111: dec.op = OP_ANDI;
          3'b001: begin
            dec.op  = OP_SLLI;
            dec.imm = shamt;
            bad     = (f7 != 7'b0);
          end
          3'b101: begin
            dec.op  = alt ? OP_SRAI : OP_SRLI;
            dec.imm = shamt;
            bad     = (f7 != 7'b0) & ~alt;
          end
        endcase
      end
      7'b0110011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f;
        // funct7=0100000 only selects SUB and SRA
        bad = (f7 != 7'b0) &
              ~(alt & ((f3 == 3'b000) | (f3 == 3'b101)));
        unique case (f3)
          3'b000: dec.op = alt ? OP_SUB : OP_ADD;
          3'b001: dec.op = OP_SLL;
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b100: dec.op = OP_XOR;
          3'b101: dec.op = alt ? OP_SRA : OP_SRL;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
        endcase
      end
      7'b0001111: dec.op = OP_NOP;
      default:    bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dec_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          dec_mem[wr_ptr] <= dec;
          pc_mem[wr_ptr]  <= in_pc;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed vectors, corner sequences and
// random traffic against a pattern-table decode/FIFO model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic        clk, rst, rdy, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, out_imm;
  logic [31:0] in_pc, out_pc;
  logic [5:0]  out_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_illegal;
  logic [2:0]  count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef enum int {FU, FJ, FI, FSH, FB, FS, FR, FZ} fmt_e;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  op;
    fmt_e        fmt;
  } pat_t;
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } ent_t;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  pat_t pats[$];
  ent_t mq[$];
  vec_t vt[18];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic void add(input logic [31:0] m,
                              input logic [31:0] v,
                              input logic [5:0] op,
                              input fmt_e f);
    pat_t p;
    p.mask = m; p.match = v; p.op = op; p.fmt = f;
    pats.push_back(p);
  endfunction

  function automatic void build_pats();
    logic [31:0] m7, m3, m10;
    m7 = 32'h7F; m3 = 32'h707F; m10 = 32'hFE00707F;
    add(m7, 32'h37, OP_LUI, FU);
    add(m7, 32'h17, OP_AUIPC, FU);
    add(m7, 32'h6F, OP_JAL, FJ);
    add(m3, 32'h67, OP_JALR, FI);
    add(m3, 32'h0063, OP_BEQ, FB);
    add(m3, 32'h1063, OP_BNE, FB);
    add(m3, 32'h4063, OP_BLT, FB);
    add(m3, 32'h5063, OP_BGE, FB);
    add(m3, 32'h6063, OP_BLTU, FB);
    add(m3, 32'h7063, OP_BGEU, FB);
    add(m3, 32'h0003, OP_LB, FI);
    add(m3, 32'h1003, OP_LH, FI);
    add(m3, 32'h2003, OP_LW, FI);
    add(m3, 32'h4003, OP_LBU, FI);
    add(m3, 32'h5003, OP_LHU, FI);
    add(m3, 32'h0023, OP_SB, FS);
    add(m3, 32'h1023, OP_SH, FS);
    add(m3, 32'h2023, OP_SW, FS);
    add(m3, 32'h0013, OP_ADDI, FI);
    add(m3, 32'h2013, OP_SLTI, FI);
    add(m3, 32'h3013, OP_SLTIU, FI);
    add(m3, 32'h4013, OP_XORI, FI);
    add(m3, 32'h6013, OP_ORI, FI);
    add(m3, 32'h7013, OP_ANDI, FI);
    add(m10, 32'h1013, OP_SLLI, FSH);
    add(m10, 32'h5013, OP_SRLI, FSH);
    add(m10, 32'h40005013, OP_SRAI, FSH);
    add(m10, 32'h0033, OP_ADD, FR);
    add(m10, 32'h40000033, OP_SUB, FR);
    add(m10, 32'h1033, OP_SLL, FR);
    add(m10, 32'h2033, OP_SLT, FR);
    add(m10, 32'h3033, OP_SLTU, FR);
    add(m10, 32'h4033, OP_XOR, FR);
    add(m10, 32'h5033, OP_SRL, FR);
    add(m10, 32'h40005033, OP_SRA, FR);
    add(m10, 32'h6033, OP_OR, FR);
    add(m10, 32'h7033, OP_AND, FR);
    add(m7, 32'h0F, OP_NOP, FZ);
  endfunction

  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t        e;
    logic        found;
    logic [31:0] sx, rd, r1, r2;
    e = '{op: OP_NOP, rs1: 0, rs2: 0, rd: 0, imm: 0,
          pc: 0, ill: 1'b1};
    found = 1'b0;
    sx = w[31] ? 32'hFFFFFFFF : 32'h0;
    rd = (w >> 7) & 31;
    r1 = (w >> 15) & 31;
    r2 = (w >> 20) & 31;
    foreach (pats[k]) begin
      if (!found && ((w & pats[k].mask) == pats[k].match)) begin
        found = 1'b1;
        e.ill = 1'b0;
        e.op  = pats[k].op;
        case (pats[k].fmt)
          FU: begin
            e.rd = 5'(rd); e.imm = w & 32'hFFFFF000;
          end
          FJ: begin
            e.rd  = 5'(rd);
            e.imm = (sx & 32'hFFF00000) | (w & 32'h000FF000) |
                    (32'(w[20]) << 11) |
                    (((w >> 21) & 32'h3FF) << 1);
          end
          FI: begin
            e.rd = 5'(rd); e.rs1 = 5'(r1);
            e.imm = (sx & 32'hFFFFF000) | (w >> 20);
          end
          FSH: begin
            e.rd = 5'(rd); e.rs1 = 5'(r1); e.imm = r2;
          end
          FB: begin
            e.rs1 = 5'(r1); e.rs2 = 5'(r2);
            e.imm = (sx & 32'hFFFFF000) | (32'(w[7]) << 11) |
                    (((w >> 25) & 32'h3F) << 5) |
                    (((w >> 8) & 32'hF) << 1);
          end
          FS: begin
            e.rs1 = 5'(r1); e.rs2 = 5'(r2);
            e.imm = (sx & 32'hFFFFF000) | ((w >> 20) & 32'hFE0) |
                    rd;
          end
          FR: begin
            e.rd = 5'(rd); e.rs1 = 5'(r1); e.rs2 = 5'(r2);
          end
          default: ;
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int          sel, k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6) begin
      k = $urandom_range(0, pats.size() - 1);
      return (r & ~pats[k].mask) | pats[k].match;
    end
    if (sel < 9) begin
      k = $urandom_range(0, 10);
      return {r[31:7], ops[k]};
    end
    return r;
  endfunction

  // Drive one cycle at posedge+1, check at negedge, advance model.
  task automatic step(input logic r, input logic f,
                      input logic iv, input logic [31:0] inst,
                      input logic [31:0] pc, input logic ordy);
    ent_t e;
    logic eir, eov, psh, pp;
    rdy = r; flush = f; in_valid = iv;
    in_inst = inst; in_pc = pc; out_ready = ordy;
    @(negedge clk);
    eir = r && !f && (mq.size() < DEPTH);
    eov = r && (mq.size() != 0);
    check("in_ready", in_ready, eir);
    check("out_valid", out_valid, eov);
    check("count", count, mq.size());
    if (eov) begin
      check("head op", out_op, mq[0].op);
      check("head rs1", out_rs1, mq[0].rs1);
      check("head rs2", out_rs2, mq[0].rs2);
      check("head rd", out_rd, mq[0].rd);
      check("head imm", out_imm, mq[0].imm);
      check("head pc", out_pc, mq[0].pc);
      check("head illegal", out_illegal, mq[0].ill);
    end
    psh = iv && eir;
    pp  = eov && ordy;
    @(posedge clk);
    if (r) begin
      if (f) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (psh) begin
          e = ref_decode(inst);
          e.pc = pc;
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    clk = 0; rst = 1; rdy = 1; flush = 0; in_valid = 1;
    in_inst = 32'h13; in_pc = 0; out_ready = 0;
    build_pats();
    vt[0]  = '{32'hFFF00093, 32'h00, OP_ADDI, 0, 0, 1, 32'hFFFFFFFF, 0};
    vt[1]  = '{32'h123452B7, 32'h04, OP_LUI, 0, 0, 5, 32'h12345000, 0};
    vt[2]  = '{32'hFFDFF0EF, 32'h08, OP_JAL, 0, 0, 1, 32'hFFFFFFFC, 0};
    vt[3]  = '{32'h00208463, 32'h0C, OP_BEQ, 1, 2, 0, 32'h8, 0};
    vt[4]  = '{32'h02009093, 32'h10, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[5]  = '{32'h00000073, 32'h14, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[6]  = '{32'h002081B3, 32'h18, OP_ADD, 1, 2, 3, 32'h0, 0};
    vt[7]  = '{32'h4020D093, 32'h1C, OP_SRAI, 1, 0, 1, 32'h2, 0};
    vt[8]  = '{32'h402081B3, 32'h20, OP_SUB, 1, 2, 3, 32'h0, 0};
    vt[9]  = '{32'h0000000F, 32'h24, OP_NOP, 0, 0, 0, 32'h0, 0};
    vt[10] = '{32'h0020A423, 32'h28, OP_SW, 1, 2, 0, 32'h8, 0};
    vt[11] = '{32'h0000B083, 32'h2C, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[12] = '{32'h00009067, 32'h30, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[13] = '{32'hFFF03093, 32'h34, OP_SLTIU, 0, 0, 1, 32'hFFFFFFFF, 0};
    vt[14] = '{32'h00002063, 32'h38, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[15] = '{32'h01F09113, 32'h3C, OP_SLLI, 1, 0, 2, 32'h1F, 0};
    vt[16] = '{32'h4020F1B3, 32'h40, OP_NOP, 0, 0, 0, 32'h0, 1};
    vt[17] = '{32'hFE208FA3, 32'h44, OP_SB, 1, 2, 0, 32'hFFFFFFFF, 0};

    #2 rst = 0;
    #1;
    check("rst count", count, 0);
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 0);
    check("rst op", out_op, OP_NOP);
    check("rst imm", out_imm, 0);
    check("rst pc", out_pc, 0);
    check("rst illegal", out_illegal, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;

    foreach (vt[i]) begin
      step(1, 0, 1, vt[i].inst, vt[i].pc, 0);
      check($sformatf("v%0d valid", i), out_valid, 1);
      check($sformatf("v%0d count", i), count, 1);
      check($sformatf("v%0d op", i), out_op, vt[i].op);
      check($sformatf("v%0d rs1", i), out_rs1, vt[i].rs1);
      check($sformatf("v%0d rs2", i), out_rs2, vt[i].rs2);
      check($sformatf("v%0d rd", i), out_rd, vt[i].rd);
      check($sformatf("v%0d imm", i), out_imm, vt[i].imm);
      check($sformatf("v%0d pc", i), out_pc, vt[i].pc);
      check($sformatf("v%0d ill", i), out_illegal, vt[i].ill);
      step(1, 0, 0, 0, 0, 1);
    end

    // back-to-back push with concurrent pop
    step(1, 0, 1, 32'h123452B7, 32'h100, 1);
    step(1, 0, 1, 32'hFFDFF0EF, 32'h104, 1);
    step(1, 0, 1, 32'h00208463, 32'h108, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 1);

    // fill, push+pop when full, wrap, drain
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 1, 32'h00100093 + (i << 20), 32'h200 + 4 * i, 0);
    check("full count", count, DEPTH);
    check("full in_ready", in_ready, 0);
    step(1, 0, 1, 32'h00500093, 32'h2F0, 1);
    check("after pop count", count, DEPTH - 1);
    check("after pop in_ready", in_ready, 1);
    check("after pop head pc", out_pc, 32'h204);
    for (int i = 0; i < 2 * DEPTH; i++)
      step(1, 0, 1, 32'h00208033 + (i << 7), 32'h300 + 4 * i,
           logic'(i % 2));
    while (mq.size() != 0) step(1, 0, 0, 0, 0, 1);
    check("drained count", count, 0);

    // flush on full queue
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 1, 32'h00000013, 32'h400 + 4 * i, 0);
    step(1, 1, 1, 32'h00000013, 32'h4F0, 1);
    check("flush count", count, 0);
    check("flush out_valid", out_valid, 0);
    step(1, 0, 1, 32'h002081B3, 32'h500, 0);
    check("post flush pc", out_pc, 32'h500);

    // rdy low holds everything
    step(1, 0, 1, 32'h00000013, 32'h504, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 32'h00000013, 32'h600, 1);
    check("rdy hold count", count, 2);
    rdy = 1;
    #1;
    check("rdy resume pc", out_pc, 32'h500);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 32'h00000013, 32'h700 + 4 * i, 0);
    check("pre arst count", count, 3);
    #2 rst = 0;
    #1;
    check("arst count", count, 0);
    check("arst out_valid", out_valid, 0);
    check("arst in_ready", in_ready, 0);
    check("arst pc", out_pc, 0);
    mq.delete();
    @(posedge clk);
    #1 rst = 1;

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, rand_inst(), $urandom,
           $urandom_range(0, 9) < 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
